// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller for the in-order pipeline.
// A DEPTH-slot shift scoreboard (slot1=EX .. slotDEPTH=WB) tracks every
// in-flight instruction past ID. From it the block derives the ID stall,
// the EX operand forward selects, flush kills, and a saturating stall count.
module pipe_hazard_scoreboard #(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned LOAD_LAT    = 2,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned FW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [FW-1:0]    occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Producer fields are carried through every slot; consumer fields are
    // only ever read in slot1, so they are kept there alone.
    logic [DEPTH:1]   valid_q, valid_d;
    logic [DEPTH:1]   wr_q, wr_d;
    logic [DEPTH:1]   ld_q, ld_d;
    logic [REG_W-1:0] rd_q [1:DEPTH];
    logic [REG_W-1:0] rd_d [1:DEPTH];
    logic [REG_W-1:0] c_rs_q, c_rs_d, c_rt_q, c_rt_d;
    logic             c_urs_q, c_urs_d, c_urt_q, c_urt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             raw_stall;
    logic             found;
    logic [REG_W-1:0] id_src [0:1];
    logic             id_use [0:1];
    logic [REG_W-1:0] c_src  [0:1];
    logic             c_use  [0:1];
    logic [FW-1:0]    fsel   [0:1];

    assign id_src[0] = id_rs;
    assign id_src[1] = id_rt;
    assign id_use[0] = id_use_rs;
    assign id_use[1] = id_use_rt;
    assign c_src[0]  = c_rs_q;
    assign c_src[1]  = c_rt_q;
    assign c_use[0]  = c_urs_q;
    assign c_use[1]  = c_urt_q;

    // ID stall: the youngest producer of an ID source is not yet forwardable
    // by the time the consumer reaches EX. A producer in the last slot writes
    // the RF this cycle and is always safe.
    always_comb begin
        raw_stall = 1'b0;
        found     = 1'b0;
        for (int unsigned s = 0; s < 2; s++) begin
            found = 1'b0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found && id_valid && id_use[s] && id_src[s] != '0 &&
                    valid_q[k] && wr_q[k] && rd_q[k] == id_src[s]) begin
                    found = 1'b1;
                    if (k < DEPTH && k + 1 <= (ld_q[k] ? LOAD_LAT : ALU_LAT))
                        raw_stall = 1'b1;
                end
            end
        end
    end

    // EX forward selects: youngest matching producer among slots 2..DEPTH,
    // used only if its result is ready, otherwise the RF value.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            fsel[s] = '0;
            for (int unsigned k = DEPTH; k >= 2; k--) begin
                if (valid_q[1] && c_use[s] && c_src[s] != '0 &&
                    valid_q[k] && wr_q[k] && rd_q[k] == c_src[s])
                    fsel[s] = (k > (ld_q[k] ? LOAD_LAT : ALU_LAT)) ? FW'(k) : '0;
            end
        end
    end

    // Control outputs and occupancy count.
    always_comb begin
        stall      = raw_stall & ~flush;
        pc_write   = ~stall;
        ifid_write = ~stall;
        fwd_a      = fsel[0];
        fwd_b      = fsel[1];
        stall_cnt  = cnt_q;
        occupancy  = '0;
        for (int unsigned k = 1; k <= DEPTH; k++)
            occupancy = occupancy + FW'(valid_q[k]);
    end

    // Next scoreboard: shift one slot, load ID or a bubble into slot1, and
    // turn the slots that flush kills into bubbles.
    always_comb begin
        valid_d = '0;
        wr_d    = '0;
        ld_d    = '0;
        rd_d    = '{default: '0};
        c_rs_d  = id_rs;
        c_rt_d  = id_rt;
        c_urs_d = id_use_rs;
        c_urt_d = id_use_rt;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wr_d[k]    = wr_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        valid_d[1] = id_valid & ~stall & ~flush;
        wr_d[1]    = id_wr_en;
        ld_d[1]    = id_is_load;
        rd_d[1]    = id_rd;
        if (flush) begin
            for (int unsigned k = 2; k <= DEPTH; k++)
                if (k <= FLUSH_SLOTS + 1)
                    valid_d[k] = 1'b0;
        end
        cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers; reset dominates flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
            rd_q    <= '{default: '0};
            c_rs_q  <= '0;
            c_rt_q  <= '0;
            c_urs_q <= 1'b0;
            c_urt_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            c_rs_q  <= c_rs_d;
            c_rt_q  <= c_rt_d;
            c_urs_q <= c_urs_d;
            c_urt_q <= c_urt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
